// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects a raw push-button.
// Produces a clean level, single-cycle press/release/long-press pulses, and a
// sticky pending flag cleared by an acknowledge. Optional accepted-press counter
// is built only when BUTTON_PRESS_COUNT_EN is defined; otherwise o_count is 0.
//
// Ports:
//   i_clk      board clock, all logic on posedge
//   i_rst      asynchronous active-low reset
//   i_button   raw asynchronous bouncing pin (polarity set by ACTIVE_LOW)
//   i_ack      clears o_pending (level-sampled, active-high)
//   o_level    debounced level, 1 = pressed
//   o_press    one-cycle pulse on accepted press
//   o_release  one-cycle pulse on accepted release
//   o_long     one-cycle pulse when hold reaches LONG_CYCLES
//   o_pending  sticky press flag, cleared by i_ack
//   o_count    accepted-press counter (8'h00 when BUTTON_PRESS_COUNT_EN undefined)
module button_conditioner #(
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 27000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button,
  input  logic       i_ack,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic       o_pending,
  output logic [7:0] o_count
);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_e;

  // Pin level when the button is not pressed.
  localparam logic             IDLE_LVL  = 1'(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0]       lcnt_q, lcnt_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   level_q, level_d;
  logic                   pending_q, pending_d;
  logic                   p;

  // Synchronizer; reset loads the released pin level so no false edge appears.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sync_q <= {SYNC_STAGES{IDLE_LVL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], i_button};
  end

  // Normalized pressed indication: 1 = pressed regardless of pin polarity.
  assign p = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_RELEASED;
      dcnt_q    <= '0;
      lcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      level_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      lcnt_q    <= lcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  // Next-state, counter update and transition pulses.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    lcnt_d    = lcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      S_RELEASED: begin
        if (p) begin
          state_d = S_PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!p) begin
          state_d = S_RELEASED;
        end else if (dcnt_q == DB_LAST) begin
          state_d = S_PRESSED;
          lcnt_d  = '0;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!p) begin
          state_d = S_RELEASE_WAIT;
          dcnt_d  = '0;
        end else if (lcnt_q != LONG_MAX) begin
          // Saturating hold counter; pulse only on the step that reaches the limit.
          lcnt_d = lcnt_q + CNT_W'(1);
          long_d = (lcnt_q == LONG_LAST);
        end
      end
      S_RELEASE_WAIT: begin
        if (p) begin
          state_d = S_PRESSED;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = S_RELEASED;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_RELEASED;
    endcase
  end

  // Level and pending flag; a press on the ack cycle keeps pending set.
  always_comb begin
    level_d   = 1'b0;
    pending_d = pending_q;
    level_d   = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
    pending_d = press_d | (pending_q & (~i_ack | press_q));
  end

`ifdef BUTTON_PRESS_COUNT_EN
  logic [7:0] count_q;

  // Accepted-press counter, wraps naturally at 8 bits.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)       count_q <= 8'h00;
    else if (press_d) count_q <= count_q + 8'h01;
  end

  assign o_count = count_q;
`else
  assign o_count = 8'h00;
`endif

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       ack;
  logic       level;
  logic       press;
  logic       rel;
  logic       lng;
  logic       pending;
  logic [7:0] count;

  int n_total;
  int n_pass;
  int n_press;
  int n_rel;
  int n_long;

`ifdef BUTTON_PRESS_COUNT_EN
  localparam logic CNT_ON = 1'b1;
`else
  localparam logic CNT_ON = 1'b0;
`endif

  button_conditioner #(
    .ACTIVE_LOW      (1),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (10),
    .CNT_W           (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_button  (btn),
    .i_ack     (ack),
    .o_level   (level),
    .o_press   (press),
    .o_release (rel),
    .o_long    (lng),
    .o_pending (pending),
    .o_count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles, sampling 1ns after each edge and tallying pulses.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_press += int'(press);
      n_rel   += int'(rel);
      n_long  += int'(lng);
    end
  endtask

  task automatic clr_cnts();
    n_press = 0;
    n_rel   = 0;
    n_long  = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clr_cnts();
    rst_n = 1'b0;
    btn   = 1'b1;
    ack   = 1'b0;

    // Reset state
    tick(3);
    chk("rst_level", 32'(level), 0);
    chk("rst_press", 32'(press), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_count", 32'(count), 0);
    rst_n = 1'b1;
    tick(3);

    // 1. Clean press: pulse 7 cycles after the pin edge
    clr_cnts();
    btn = 1'b0;
    tick(6);
    chk("t1_press_early", 32'(press), 0);
    chk("t1_level_early", 32'(level), 0);
    tick(1);
    chk("t1_press", 32'(press), 1);
    chk("t1_level", 32'(level), 1);
    chk("t1_pending", 32'(pending), 1);
    chk("t1_count", 32'(count), 32'(CNT_ON));
    tick(1);
    chk("t1_press_off", 32'(press), 0);
    tick(12);
    chk("t1_press_cnt", 32'(n_press), 1);
    chk("t1_level_hold", 32'(level), 1);
    btn = 1'b1;
    tick(6);
    chk("t1_rel_early", 32'(rel), 0);
    tick(1);
    chk("t1_release", 32'(rel), 1);
    chk("t1_level_fall", 32'(level), 0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t1_ack_clear", 32'(pending), 0);
    tick(4);

    // 2. Bounce rejection, then a real press
    clr_cnts();
    btn = 1'b0; tick(3);
    btn = 1'b1; tick(2);
    btn = 1'b0; tick(3);
    btn = 1'b1; tick(10);
    chk("t2_no_press", 32'(n_press), 0);
    chk("t2_level", 32'(level), 0);
    chk("t2_pending", 32'(pending), 0);
    btn = 1'b0;
    tick(10);
    chk("t2_one_press", 32'(n_press), 1);
    chk("t2_level_hi", 32'(level), 1);
    btn = 1'b1;
    tick(10);
    chk("t2_one_release", 32'(n_rel), 1);
    chk("t2_level_lo", 32'(level), 0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(2);

    // 3. Long press: one o_long 10 cycles after o_press
    clr_cnts();
    btn = 1'b0;
    tick(7);
    chk("t3_press", 32'(press), 1);
    tick(9);
    chk("t3_long_early", 32'(lng), 0);
    tick(1);
    chk("t3_long", 32'(lng), 1);
    tick(1);
    chk("t3_long_off", 32'(lng), 0);
    tick(12);
    chk("t3_long_cnt", 32'(n_long), 1);
    btn = 1'b1;
    tick(6);
    chk("t3_rel_early", 32'(rel), 0);
    chk("t3_level_hold", 32'(level), 1);
    tick(1);
    chk("t3_release", 32'(rel), 1);
    chk("t3_level_fall", 32'(level), 0);
    chk("t3_press_cnt", 32'(n_press), 1);
    tick(3);

    // 4. Ack handshake, including ack coinciding with a press pulse
    chk("t4_pending_set", 32'(pending), 1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_pending_clr", 32'(pending), 0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_ack_idle", 32'(pending), 0);
    btn = 1'b0;
    tick(7);
    chk("t4_press2", 32'(press), 1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_set_wins", 32'(pending), 1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_pending_clr2", 32'(pending), 0);
    btn = 1'b1;
    tick(10);

    // 5. Reset in the middle of a debounce window
    clr_cnts();
    btn = 1'b0;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("t5_level", 32'(level), 0);
    chk("t5_pending", 32'(pending), 0);
    chk("t5_press", 32'(press), 0);
    chk("t5_count", 32'(count), 0);
    btn = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("t5_no_press", 32'(n_press), 0);
    chk("t5_no_release", 32'(n_rel), 0);
    chk("t5_level_after", 32'(level), 0);

    // 6. Press counter: 257 presses wrap to 1, or stays 0 when not built
    clr_cnts();
    for (int i = 0; i < 257; i++) begin
      btn = 1'b0;
      tick(8);
      btn = 1'b1;
      tick(8);
    end
    chk("t6_press_cnt", 32'(n_press), 257);
    chk("t6_count", 32'(count), CNT_ON ? 32'h1 : 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the CPU's button input in the board top level. It synchronizes, debounces and edge-detects the raw active-low board push-button. Outputs are a clean level, single-cycle press/release/long-press pulses, and a sticky pending flag with an acknowledge handshake. It runs on the fast board clock, so the slow divided CPU clock can sample o_pending and never miss a press.

Parameters:
ACTIVE_LOW, 1, raw i_button polarity; 1 = pin reads 0 when pressed
SYNC_STAGES, 2, synchronizer flop count, legal range 2..4
DEBOUNCE_CYCLES, 270000, cycles the synced input must stay stable to accept a change (10 ms at 27 MHz)
LONG_CYCLES, 27000000, cycles held in PRESSED before o_long fires (1 s at 27 MHz)
CNT_W, 25, width of the debounce and long-press counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES)

Ports:
i_clk  input  1  board clock, all logic on posedge
i_rst  input  1  asynchronous active-low reset
i_button  input  1  raw, asynchronous, bouncing pin
i_ack  input  1  clears o_pending (level-sampled, active-high)
o_level  output  1  debounced level, 1 = pressed
o_press  output  1  one-cycle pulse on accepted press
o_release  output  1  one-cycle pulse on accepted release
o_long  output  1  one-cycle pulse when hold reaches LONG_CYCLES
o_pending  output  1  sticky: set by press, cleared by i_ack
o_count  output  8  accepted-press counter (see Optional Feature)

Behaviour:
- Reset (i_rst=0, asynchronous): sync chain loads the released level. State=S_RELEASED, both counters 0. All outputs 0. Reset is honoured mid-debounce or mid-hold with no pulse emitted afterwards.
- Synchronizer: SYNC_STAGES flops; output p = synced i_button XOR ACTIVE_LOW inverted, so p = 1 means pressed.
- FSM, registered, one transition per cycle:
  - S_RELEASED: p=1 -> S_PRESS_WAIT, dcnt<=0.
  - S_PRESS_WAIT: p=0 -> S_RELEASED (bounce rejected, no pulse). p=1 with dcnt==DEBOUNCE_CYCLES-1 -> S_PRESSED, lcnt<=0, o_press=1 next cycle. Otherwise dcnt++.
  - S_PRESSED: p=0 -> S_RELEASE_WAIT, dcnt<=0. Otherwise lcnt++ saturating at LONG_CYCLES; o_long=1 for exactly the one cycle lcnt becomes LONG_CYCLES. At most one o_long per press.
  - S_RELEASE_WAIT: p=1 -> S_PRESSED (bounce, no pulse, lcnt holds). p=0 with dcnt==DEBOUNCE_CYCLES-1 -> S_RELEASED, o_release=1 next cycle. Otherwise dcnt++.
- o_level=1 in S_PRESSED and S_RELEASE_WAIT, 0 otherwise. It rises in the same cycle o_press pulses and falls in the same cycle o_release pulses.
- Latency: from the first cycle p=1 (stable) to o_press high = DEBOUNCE_CYCLES+1 cycles. Add SYNC_STAGES for latency from the pin.
- o_press and o_release are never high together. A press/release pair needs at least 2*DEBOUNCE_CYCLES cycles.
- o_pending: set the cycle o_press rises. Cleared on a cycle with i_ack=1 and no o_press. If i_ack and o_press coincide, set wins (o_pending stays 1). i_ack while o_pending=0 has no effect.
- Counters never wrap. dcnt is bounded by the FSM; lcnt saturates.

Optional Feature:
BUTTON_PRESS_COUNT_EN
- Defined: o_count is an 8-bit register, reset 0. It increments by 1 in the cycle o_press rises and wraps 8'hFF -> 8'h00.
- Undefined: o_count is tied to 8'h00 and no counter flops exist. The port stays present so the instantiation is identical in both builds.

Test Plan:
Use ACTIVE_LOW=1, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10 unless stated.
1. Clean press: drive i_button 1->0 and hold 20 cycles -> o_press high for exactly 1 cycle, 7 cycles after the pin edge (2 sync + 5). o_level=1 from that cycle. o_pending=1.
2. Bounce rejection: pulse i_button low 3 cycles, high 2, low 3, high -> no o_press, o_level stays 0, o_pending 0. Then hold low 10 cycles -> exactly one o_press.
3. Long press: hold i_button low 30 cycles -> one o_press, then exactly one o_long 10 cycles later, no further o_long. On release -> one o_release 7 cycles after the rising pin edge, o_level falls.
4. Ack handshake: after a press, o_pending=1. Assert i_ack 1 cycle -> o_pending 0 next cycle. Then assert i_ack in the same cycle as a second o_press -> o_pending remains 1.
5. Reset mid-operation: hold button low 5 cycles (in S_PRESS_WAIT), pull i_rst low 1 cycle -> all outputs 0 immediately. Release button, deassert reset -> no o_press or o_release ever fires.
6. With BUTTON_PRESS_COUNT_EN defined: perform 257 clean presses -> o_count reads 8'h01. Without the macro -> o_count constant 8'h00.
